// File: rtl/seg_scan_capture_if.sv
// Seven-segment scan bus as seen by the readback monitor: digit selects and
// segment byte coming in, decoded per-digit results and frame pulse going out.
interface seg_scan_capture_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   an;          // digit select, active-low
  logic [0:7]          oct;         // [0:6] = segments a..g, [7] = dot, active-low
  logic [4*DIGITS-1:0] bcd_out;     // decoded value, digit i at [4i+3:4i]
  logic [DIGITS-1:0]   dot_out;     // decoded dot per digit, 1 = lit
  logic [DIGITS-1:0]   err_out;     // last capture of digit i was not a known glyph
  logic                frame_done;  // one-cycle pulse when all digits were captured

  // Display driver / bench side
  modport master (
    output an, oct,
    input  bcd_out, dot_out, err_out, frame_done
  );

  // Capture monitor side
  modport slave (
    input  an, oct,
    output bcd_out, dot_out, err_out, frame_done
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Seven-segment scan readback: waits for each digit's select/segment pattern
// to be stable for STABLE cycles, decodes it back to hex + dot and stores it
// per digit. Raises frame_done once every digit has been captured.
module seg_scan_capture #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_capture_if.slave bus
);

  localparam int CW = $clog2(STABLE + 1);

  logic [DIGITS-1:0]   an_q;
  logic [0:7]          oct_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   dot_q, dot_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                fd_q, fd_d;

  logic                same;
  logic                capture;
  logic [4:0]          dec;
  logic [DIGITS-1:0]   seen_tmp;

  // True when exactly one active-low select bit is asserted.
  function automatic logic one_low(input logic [DIGITS-1:0] a_n);
    int n;
    n = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!a_n[i]) n++;
    end
    return (n == 1);
  endfunction

  // Maps an active-low a..g pattern (a in the MSB) to {valid, hex value}.
  // Only the exact glyphs below are accepted; anything else is invalid.
  function automatic logic [4:0] seg_decode(input logic [0:6] seg);
    case (seg)
      7'b0000001: return {1'b1, 4'h0};
      7'b1001111: return {1'b1, 4'h1};
      7'b0010010: return {1'b1, 4'h2};
      7'b0000110: return {1'b1, 4'h3};
      7'b1001100: return {1'b1, 4'h4};
      7'b0100100: return {1'b1, 4'h5};
      7'b0100000: return {1'b1, 4'h6};
      7'b0001111: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0000100: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b1100000: return {1'b1, 4'hB};
      7'b0110001: return {1'b1, 4'hC};
      7'b1000010: return {1'b1, 4'hD};
      7'b0110000: return {1'b1, 4'hE};
      7'b0111000: return {1'b1, 4'hF};
      default:    return {1'b0, 4'h0};
    endcase
  endfunction

  // Stability counter, capture decision and per-digit result update.
  always_comb begin
    same     = (bus.an == an_q) && (bus.oct == oct_q);
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    dot_d    = dot_q;
    err_d    = err_q;
    seen_d   = seen_q;
    fd_d     = 1'b0;
    seen_tmp = seen_q;
    dec      = seg_decode(oct_q[0:6]);

    if (!same) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CW'(STABLE)) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Fires on the single cycle the count crosses STABLE-1, so a long hold
    // produces exactly one capture.
    capture = same && (cnt_q == CW'(STABLE - 1)) && one_low(an_q);

    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (!an_q[i]) begin
          bcd_d[4*i +: 4] = dec[3:0];
          dot_d[i]        = ~oct_q[7];
          err_d[i]        = ~dec[4];
        end
      end
      seen_tmp = seen_q | ~an_q;
      if (&seen_tmp) begin
        fd_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_tmp;
      end
    end
  end

  // State registers: input sample, counter, stored digits, frame tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '0;
      oct_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      dot_q  <= '0;
      err_q  <= '0;
      seen_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      an_q   <= bus.an;
      oct_q  <= bus.oct;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
      dot_q  <= dot_d;
      err_q  <= err_d;
      seen_q <= seen_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.dot_out    = dot_q;
  assign bus.err_out    = err_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture (DIGITS=4, STABLE=4): a vector table
// for steady-hold captures plus hand sequences for latency, glitch and reset.
module tb_seg_scan_capture;

  logic clk;
  logic rst_n;

  seg_scan_capture_if #(.DIGITS(4)) bus ();

  seg_scan_capture #(.DIGITS(4), .STABLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  an;
    logic [7:0]  oct;
    int          hold;
    logic [15:0] bcd;
    logic [3:0]  dot;
    logic [3:0]  err;
    int          fd_at;   // hold cycle on which frame_done is seen, 0 = never
  } vec_t;

  vec_t vecs [9];

  int n_cmp;
  int n_bad;
  int fd_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; samples 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.frame_done === 1'b1) fd_total++;
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] oct);
    bus.an  = an;
    bus.oct = oct;
  endtask

  initial begin
    int fd_cnt;
    int fd_at;
    int fd_base;

    n_cmp    = 0;
    n_bad    = 0;
    fd_total = 0;

    // Segment bytes: oct[0:6] = a..g, then dot (0 = lit).
    vecs[0] = '{"scan_d0_1",  4'b1110, 8'b1001111_1, 6,  16'h0001, 4'b0000, 4'b0000, 0};
    vecs[1] = '{"scan_d1_2",  4'b1101, 8'b0010010_1, 6,  16'h0021, 4'b0000, 4'b0000, 0};
    vecs[2] = '{"scan_d2_A",  4'b1011, 8'b0001000_1, 6,  16'h0A21, 4'b0000, 4'b0000, 0};
    vecs[3] = '{"scan_d3_F",  4'b0111, 8'b0111000_1, 6,  16'hFA21, 4'b0000, 4'b0000, 4};
    vecs[4] = '{"blank_err",  4'b1110, 8'b1111111_1, 4,  16'hFA20, 4'b0000, 4'b0001, 0};
    vecs[5] = '{"eight_ok",   4'b1110, 8'b0000000_1, 4,  16'hFA28, 4'b0000, 4'b0000, 0};
    vecs[6] = '{"two_low_an", 4'b1100, 8'b0000001_0, 10, 16'hFA28, 4'b0000, 4'b0000, 0};
    vecs[7] = '{"no_low_an",  4'b1111, 8'b0000001_0, 10, 16'hFA28, 4'b0000, 4'b0000, 0};
    vecs[8] = '{"d2_9_dot",   4'b1011, 8'b0000100_0, 4,  16'hF928, 4'b0100, 4'b0000, 0};

    // Reset state
    rst_n = 1'b0;
    drive(4'b1111, 8'hFF);
    step();
    step();
    check("rst_bcd", 32'(bus.bcd_out), 32'h0);
    check("rst_dot", 32'(bus.dot_out), 32'h0);
    check("rst_err", 32'(bus.err_out), 32'h0);
    check("rst_fd",  32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;
    step();

    // Latency: digit0 = 3 with dot, appears on the 4th edge, then holds
    drive(4'b1110, 8'b0000110_0);
    step(); step(); step();
    check("lat_early_bcd", 32'(bus.bcd_out), 32'h0);
    step();
    check("lat_bcd", 32'(bus.bcd_out), 32'h0003);
    check("lat_dot", 32'(bus.dot_out), 32'b0001);
    check("lat_err", 32'(bus.err_out), 32'h0);
    step(); step(); step(); step();
    check("lat_hold_bcd", 32'(bus.bcd_out), 32'h0003);
    check("lat_hold_fd",  32'(fd_total), 32'h0);

    // Table of steady holds
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].an, vecs[v].oct);
      fd_cnt = 0;
      fd_at  = 0;
      for (int c = 1; c <= vecs[v].hold; c++) begin
        step();
        if (bus.frame_done === 1'b1) begin
          fd_cnt++;
          fd_at = c;
        end
      end
      check({vecs[v].name, "_bcd"},   32'(bus.bcd_out), 32'(vecs[v].bcd));
      check({vecs[v].name, "_dot"},   32'(bus.dot_out), 32'(vecs[v].dot));
      check({vecs[v].name, "_err"},   32'(bus.err_out), 32'(vecs[v].err));
      check({vecs[v].name, "_fdcnt"}, 32'(fd_cnt), (vecs[v].fd_at != 0) ? 32'd1 : 32'd0);
      check({vecs[v].name, "_fdat"},  32'(fd_at), 32'(vecs[v].fd_at));
    end

    // Glitch: 5 x3, one cycle of 7, 5 x3 -> nothing; 4th cycle of 5 -> capture
    fd_base = fd_total;
    drive(4'b1101, 8'b0100100_1);
    step(); step(); step();
    drive(4'b1101, 8'b0001111_1);
    step();
    drive(4'b1101, 8'b0100100_1);
    step(); step(); step();
    check("glitch_nocap_bcd", 32'(bus.bcd_out), 32'hF928);
    step();
    check("glitch_cap_bcd", 32'(bus.bcd_out), 32'hF958);
    check("glitch_cap_dot", 32'(bus.dot_out), 32'b0100);
    check("glitch_fd", 32'(fd_total - fd_base), 32'h0);

    // Reset mid-hold with digits 0..2 already seen
    drive(4'b0111, 8'b1000010_1);
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_bcd", 32'(bus.bcd_out), 32'h0);
    check("midrst_dot", 32'(bus.dot_out), 32'h0);
    check("midrst_err", 32'(bus.err_out), 32'h0);
    check("midrst_fd",  32'(bus.frame_done), 32'h0);
    step(); step();
    rst_n = 1'b1;
    fd_base = fd_total;
    step(); step(); step();
    check("post_rst_early_bcd", 32'(bus.bcd_out), 32'h0);
    step();
    check("post_rst_bcd", 32'(bus.bcd_out), 32'hD000);
    check("post_rst_err", 32'(bus.err_out), 32'h0);
    step(); step();
    check("post_rst_fd", 32'(fd_total - fd_base), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive side of the multiplexed seven-segment display interface: samples the active-low digit-select lines and the active-low segment byte oct[0:7] (segments a..g on bits 0..6, dot on bit 7).
- Waits until each digit's pattern is stable, then decodes it back to a 4-bit hex value plus a dot flag and stores it per digit.
- Used as a display readback/self-check monitor and as the scoreboard front-end in display-path benches.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8)
- STABLE, 4, consecutive identical input cycles required before capture (2..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- an  in  DIGITS  digit select, active-low, bit i selects digit i
- oct  in  8  segment byte, index [0:7], active-low; [0:6] = a..g, [7] = dot
- bcd_out  out  4*DIGITS  decoded value; digit i at [4i+3:4i]
- dot_out  out  DIGITS  decoded dot per digit, 1 = lit
- err_out  out  DIGITS  1 = last capture for digit i was an unrecognised pattern
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse

Behaviour:
- Reset (async assert, sync release): bcd_out=0, dot_out=0, err_out=0, frame_done=0, seen mask=0, stability counter=0, input register=0.
- Input stage: {an, oct} is registered every cycle into r_in.
- Counter:
  - If the current {an, oct} differs from r_in, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at STABLE.
- Capture condition: cnt==STABLE-1, {an, oct}==r_in, and exactly one bit of r_in.an is 0.
  - Capture fires once per stable hold.
  - Zero or multiple low an bits: nothing is captured and the seen mask is unchanged.
- Latency: with an input change presented before sampling edge 1 and held, the outputs change after edge STABLE. For STABLE=4 this is edge 4.
- Decode table, oct[0:6] -> value (exact codes only):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=b
  - 0110001=C, 1000010=d, 0110000=E, 0111000=F
- Any other pattern, including all segments off (1111111): bcd_out digit <= 0, err_out[i] <= 1.
- Valid pattern: err_out[i] <= 0.
- dot_out[i] <= ~oct[7] on every capture, valid or not.
- Seen mask: bit i is set on capture of digit i.
  - When the mask, including the capture in the current cycle, becomes all ones: frame_done=1 for exactly one cycle and the mask clears to 0 on that edge.
- Recapturing an already-seen digit before the frame completes: the stored value is overwritten and the mask is unchanged.
- Only the captured digit's slots change. All other digits hold their values.
- Reset mid-hold: counter and mask clear; capture requires a full new STABLE hold after release.
- Glitch: any single-cycle change restarts the count. A value that returns after the glitch must then hold a full STABLE again.

Test Plan:
1. Reset, then an=1110, oct=0000110_0 held 4 cycles -> after edge 4: digit0=3, dot_out[0]=1, err_out[0]=0; no further change while held.
2. Scan digits 0..3 with patterns for 1, 2, A, F (an=1110, 1101, 1011, 0111), 6 cycles each, dot off -> bcd_out=16'hFA21, dot_out=0000, frame_done high exactly one cycle coincident with the digit-3 capture.
3. an=1110, oct=1111111_1 held 4 cycles -> digit0=0, err_out[0]=1; then 0000000_1 held 4 cycles -> digit0=8, err_out[0]=0.
4. an=1100 or an=1111 with a valid pattern held 10 cycles -> no output change, no frame_done.
5. an=1101, oct for 5 held 3 cycles, one glitch cycle of 7, then 5 held 3 cycles -> no capture; 5 held a 4th cycle -> digit1=5.
6. Assert rst_n=0 mid-scan after digits 0..2 captured -> all outputs 0 immediately; after release, capture only digit 3 -> no frame_done.
